spi_controller: RTL and testbench

- SPI initiator (mode 0: CPOL=0, CPHA=0) that drives SCLK, COPI and nCS to program the spi_peripheral register bank from on-chip logic.
- Accepts one 16-bit command per valid/ready handshake and serialises it MSB-first.
- Paces SCLK slowly enough for the peripheral's synchroniser and edge-detect chain, and holds nCS high for a gap between frames so the peripheral can commit each frame.

---
 rtl/spi_pkg.sv | 33 +++
 rtl/spi_sclk_gen.sv | 36 +++
 rtl/spi_controller.sv | 129 ++++++++++++
 tb/tb_spi_controller.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// Shared SPI frame layout, controller state encoding and peripheral register map.
package spi_pkg;

   localparam int SPI_FRAME_W  = 16;
   localparam int SPI_RW_BIT   = 15;
   localparam int SPI_ADDR_MSB = 14;
   localparam int SPI_ADDR_LSB = 8;
   localparam int SPI_DATA_W   = 8;

   typedef enum logic [2:0] {
      IDLE,
      SETUP,
      SHIFT,
      HOLD,
      GAP
   } spi_state_e;

   localparam logic [6:0] REG_EN_REG_OUT_7_0  = 7'h00;
   localparam logic [6:0] REG_EN_REG_OUT_15_8 = 7'h01;
   localparam logic [6:0] REG_EN_REG_PWM_7_0  = 7'h02;
   localparam logic [6:0] REG_EN_REG_PWM_15_8 = 7'h03;
   localparam logic [6:0] REG_PWM_DUTY_CYCLE  = 7'h04;

   // Read frames carry an all-zero data field.
   function automatic logic [SPI_FRAME_W-1:0] spi_frame(
      input logic                  wr,
      input logic [6:0]            addr,
      input logic [SPI_DATA_W-1:0] data
   );
      return {wr, addr, (wr ? data : {SPI_DATA_W{1'b0}})};
   endfunction

endpackage

// File: rtl/spi_sclk_gen.sv
// SCLK pacer: counts HALF_DIV clk cycles per half-period and strobes the edge about to happen.
module spi_sclk_gen #(
   parameter int HALF_DIV = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic en,
   output logic sclk,
   output logic rise,
   output logic fall
);

   localparam int            CW   = (HALF_DIV > 1) ? $clog2(HALF_DIV) : 1;
   localparam logic [CW-1:0] TERM = CW'(HALF_DIV - 1);

   logic [CW-1:0] cnt_q;
   logic          tick;

   assign tick = en && (cnt_q == TERM);
   assign rise = tick && !sclk;
   assign fall = tick && sclk;

   // NOTE: clocked state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (rst || !en) begin
         cnt_q <= '0;
         sclk  <= 1'b0;
      end else if (tick) begin
         cnt_q <= '0;
         sclk  <= !sclk;
      end else begin
         cnt_q <= cnt_q + CW'(1);
      end
   end

endmodule

// File: rtl/spi_controller.sv
// SPI mode-0 initiator: one 16-bit command per handshake, MSB first, paced for the peripheral.
// Define SPI_CTRL_READBACK_EN to add cipo capture with rsp_data/rsp_valid.
module spi_controller
   import spi_pkg::*;
#(
   parameter int HALF_DIV  = 4,
   parameter int SETUP_CYC = 2,
   parameter int HOLD_CYC  = 2,
   parameter int GAP_CYC   = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       cmd_valid,
   output logic       cmd_ready,
   input  logic       cmd_write,
   input  logic [6:0] cmd_addr,
   input  logic [7:0] cmd_data,
   output logic       busy,
   output logic       done,
   output logic       sclk,
   output logic       copi,
   output logic       ncs
`ifdef SPI_CTRL_READBACK_EN
   ,
   input  logic       cipo,
   output logic [7:0] rsp_data,
   output logic       rsp_valid
`endif
);

   localparam int PH_MAX = (SETUP_CYC > HOLD_CYC) ?
                           ((SETUP_CYC > GAP_CYC) ? SETUP_CYC : GAP_CYC) :
                           ((HOLD_CYC  > GAP_CYC) ? HOLD_CYC  : GAP_CYC);
   localparam int            PW      = $clog2(PH_MAX + 1);
   localparam logic [PW-1:0] SETUP_T = PW'(SETUP_CYC - 1);
   localparam logic [PW-1:0] HOLD_T  = PW'(HOLD_CYC - 1);
   localparam logic [PW-1:0] GAP_T   = PW'(GAP_CYC - 1);

   spi_state_e             state_q, state_d;
   logic [PW-1:0]          ph_q;
   logic [3:0]             bit_q;
   logic [SPI_FRAME_W-1:0] sr_q;
   logic                   ncs_q;
   logic                   accept, last_bit, sclk_rise, sclk_fall, frame_end;

   assign cmd_ready = (state_q == IDLE) && !rst;
   assign busy      = !cmd_ready;
   assign accept    = cmd_valid && cmd_ready;
   assign last_bit  = (bit_q == 4'd15);
   assign frame_end = (state_q == HOLD) && (state_d == GAP);
   assign done      = (state_q == GAP) && (ph_q == GAP_T) && !rst;
   assign ncs       = ncs_q;
   assign copi      = sr_q[SPI_FRAME_W-1];

   spi_sclk_gen #(.HALF_DIV(HALF_DIV)) u_sclk_gen (
      .clk  (clk),
      .rst  (rst),
      .en   (state_q == SHIFT),
      .sclk (sclk),
      .rise (sclk_rise),
      .fall (sclk_fall)
   );

   // NOTE: state_d gets a default before the case so no path leaves it unassigned (no latch).
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (accept)                  state_d = SETUP;
         SETUP:   if (ph_q == SETUP_T)         state_d = SHIFT;
         SHIFT:   if (sclk_fall && last_bit)   state_d = HOLD;
         HOLD:    if (ph_q == HOLD_T)          state_d = GAP;
         GAP:     if (ph_q == GAP_T)           state_d = IDLE;
         default:                              state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         ph_q    <= '0;
         bit_q   <= '0;
         sr_q    <= '0;
         ncs_q   <= 1'b1;
      end else begin
         state_q <= state_d;
         if (state_d != state_q)
            ph_q <= '0;
         else if (state_q inside {SETUP, HOLD, GAP})
            ph_q <= ph_q + PW'(1);

         // copi changes on the same edge sclk falls; bit 0 is held into HOLD.
         if (accept) begin
            sr_q  <= spi_frame(cmd_write, cmd_addr, cmd_data);
            bit_q <= '0;
            ncs_q <= 1'b0;
         end else if (sclk_fall && !last_bit) begin
            sr_q  <= {sr_q[SPI_FRAME_W-2:0], 1'b0};
            bit_q <= bit_q + 4'd1;
         end else if (frame_end) begin
            sr_q  <= '0;
            ncs_q <= 1'b1;
         end
      end
   end

`ifdef SPI_CTRL_READBACK_EN
   // Only the data field of the captured frame is ever reported, so only its 8 bits are kept.
   logic [SPI_DATA_W-1:0] cap_q;
   logic [SPI_DATA_W-1:0] rsp_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         cap_q <= '0;
         rsp_q <= '0;
      end else begin
         if (accept)
            cap_q <= '0;
         else if (sclk_rise)
            cap_q <= {cap_q[SPI_DATA_W-2:0], cipo};
         if (frame_end)
            rsp_q <= cap_q;
      end
   end

   assign rsp_data  = rsp_q;
   assign rsp_valid = done;
`endif

endmodule

// File: tb/tb_spi_controller.sv
// Self-checking bench for spi_controller: table of commands, bus monitor with scoreboard, corner sequences.
`timescale 1ns/1ps
module tb_spi_controller;

   localparam int HALF_DIV  = 4;
   localparam int SETUP_CYC = 2;
   localparam int HOLD_CYC  = 2;
   localparam int GAP_CYC   = 4;
   localparam int LAT       = 1 + SETUP_CYC + 32*HALF_DIV + HOLD_CYC + GAP_CYC;
   localparam int LOW_LEN   = SETUP_CYC + 32*HALF_DIV + HOLD_CYC;
   localparam int TMO       = 400;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       cmd_valid = 1'b0;
   logic       cmd_write = 1'b0;
   logic [6:0] cmd_addr  = '0;
   logic [7:0] cmd_data  = '0;
   logic       cmd_ready, busy, done, sclk, copi, ncs;
`ifdef SPI_CTRL_READBACK_EN
   logic       cipo = 1'b0;
   logic [7:0] rsp_data;
   logic       rsp_valid;
`endif

   spi_controller #(
      .HALF_DIV(HALF_DIV), .SETUP_CYC(SETUP_CYC), .HOLD_CYC(HOLD_CYC), .GAP_CYC(GAP_CYC)
   ) dut (
      .clk(clk), .rst(rst),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_write(cmd_write), .cmd_addr(cmd_addr), .cmd_data(cmd_data),
      .busy(busy), .done(done), .sclk(sclk), .copi(copi), .ncs(ncs)
`ifdef SPI_CTRL_READBACK_EN
      , .cipo(cipo), .rsp_data(rsp_data), .rsp_valid(rsp_valid)
`endif
   );

   always #5 clk = ~clk;

   int tests = 0;
   int fails = 0;
   int cyc   = 0;

   always @(posedge clk) cyc++;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // ---------------- bus monitor, scoreboard, peripheral register model ----------------
   logic [15:0] sb[$];
   logic [7:0]  regs[5];
   logic [15:0] shreg = '0;
   logic        sclk_p = 1'b0, ncs_p = 1'b1;
   int bits = 0, rise_cnt = 0, sclk_bad = 0, rv_bad = 0;
   int low_len = 0, high_len = 0, last_low = 0, last_high = 0;
   int done_cnt = 0, done_cyc = 0, trunc_bits = -1;

   initial foreach (regs[i]) regs[i] = 8'h00;

   task automatic frame_end_mon();
      logic [15:0] exp;
      if (bits == 16) begin
         check("sb_nonempty", sb.size() > 0, 1);
         if (sb.size() > 0) begin
            exp = sb.pop_front();
            check("frame", shreg, exp);
         end
         if (shreg[15] && shreg[14:8] < 7'd5) regs[shreg[10:8]] = shreg[7:0];
      end else begin
         trunc_bits = bits;
      end
   endtask

   always @(negedge clk) begin
      if (ncs_p && !ncs) begin
         bits      = 0;
         last_high = high_len;
         high_len  = 0;
      end
      if (!ncs_p && ncs) begin
         last_low = low_len;
         low_len  = 0;
         frame_end_mon();
      end
      if (ncs) high_len++; else low_len++;
      if (sclk && !sclk_p) begin
         if (ncs) sclk_bad++;
         shreg = {shreg[14:0], copi};
         bits++;
         rise_cnt++;
      end
      if (done) begin
         done_cnt++;
         done_cyc = cyc;
`ifdef SPI_CTRL_READBACK_EN
         check("rsp_data", rsp_data, 8'h3C);
`endif
      end
`ifdef SPI_CTRL_READBACK_EN
      if (rsp_valid !== done) rv_bad++;
`endif
      sclk_p = sclk;
      ncs_p  = ncs;
   end

`ifdef SPI_CTRL_READBACK_EN
   // Peripheral-side model: presents 0x003C MSB first, advancing on sclk falls.
   logic [15:0] cipo_pat = 16'h003C;
   int cidx = 15;
   always @(negedge ncs) begin
      cidx = 15;
      cipo = cipo_pat[cidx];
   end
   always @(negedge sclk) begin
      if (!ncs && cidx > 0) begin
         cidx--;
         cipo = cipo_pat[cidx];
      end
   end
`endif

   // ---------------- drivers ----------------
   task automatic send(input logic w, input logic [6:0] a, input logic [7:0] d,
                       input logic [15:0] exp, input bit keep, output int hs_cyc);
      int n = 0;
      @(negedge clk);
      cmd_valid = 1'b1;
      cmd_write = w;
      cmd_addr  = a;
      cmd_data  = d;
      while (!cmd_ready && n < TMO) begin
         @(negedge clk);
         n++;
      end
      if (n >= TMO) check("accept_timeout", n, 0);
      hs_cyc = cyc;
      sb.push_back(exp);
      @(posedge clk);
      #1;
      if (!keep) cmd_valid = 1'b0;
   endtask

   task automatic wait_ready(output int ready_cyc);
      int n = 0;
      @(negedge clk);
      while (!cmd_ready && n < TMO) begin
         @(negedge clk);
         n++;
      end
      if (n >= TMO) check("ready_timeout", n, 0);
      ready_cyc = cyc;
   endtask

   typedef struct {
      logic        w;
      logic [6:0]  addr;
      logic [7:0]  data;
      logic [15:0] frame;
   } vec_t;

   vec_t vecs[6];

   initial begin
      #1ms;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int hs, hs2, rdy, r0, d0, n;

      vecs[0] = '{1'b1, 7'h00, 8'hA5, 16'h80A5};
      vecs[1] = '{1'b0, 7'h04, 8'hFF, 16'h0400};
      vecs[2] = '{1'b1, 7'h7F, 8'h3C, 16'hFF3C};
      vecs[3] = '{1'b0, 7'h2A, 8'h00, 16'h2A00};
      vecs[4] = '{1'b1, 7'h02, 8'h5A, 16'h825A};
      vecs[5] = '{1'b1, 7'h55, 8'hC3, 16'hD5C3};

      // Reset state
      repeat (3) @(negedge clk);
      check("rst_ncs", ncs, 1'b1);
      check("rst_sclk", sclk, 1'b0);
      check("rst_copi", copi, 1'b0);
      check("rst_done", done, 1'b0);
      check("rst_ready_in_rst", cmd_ready, 1'b0);
      rst = 1'b0;
      #1;
      check("rst_ready", cmd_ready, 1'b1);
      check("rst_busy", busy, 1'b0);

      // Table-driven single frames
      foreach (vecs[i]) begin
         r0 = rise_cnt;
         d0 = done_cnt;
         send(vecs[i].w, vecs[i].addr, vecs[i].data, vecs[i].frame, 1'b0, hs);
         wait_ready(rdy);
         check($sformatf("latency[%0d]", i), rdy - hs, LAT);
         check($sformatf("done_cyc[%0d]", i), done_cyc, rdy - 1);
         check($sformatf("done_cnt[%0d]", i), done_cnt - d0, 1);
         check($sformatf("rises[%0d]", i), rise_cnt - r0, 16);
         check($sformatf("ncs_low[%0d]", i), last_low, LOW_LEN);
      end

      // Back-to-back with cmd_valid held
      send(1'b1, 7'h01, 8'hFF, 16'h81FF, 1'b1, hs);
      send(1'b1, 7'h04, 8'h80, 16'h8480, 1'b0, hs2);
      wait_ready(rdy);
      check("b2b_accept", hs2 - hs, LAT);
      check("b2b_gap", last_high, GAP_CYC + 1);
      check("b2b_latency", rdy - hs2, LAT);

      // Reset after the 5th sclk rise aborts the frame
      r0 = rise_cnt;
      d0 = done_cnt;
      send(1'b1, 7'h00, 8'h5A, 16'h805A, 1'b0, hs);
      n = 0;
      while (rise_cnt < r0 + 5 && n < TMO) begin
         @(negedge clk);
         n++;
      end
      check("abort_rise5", rise_cnt - r0, 5);
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      #1;
      check("abort_ncs", ncs, 1'b1);
      check("abort_sclk", sclk, 1'b0);
      check("abort_copi", copi, 1'b0);
      check("abort_busy", busy, 1'b0);
      check("abort_done", done, 1'b0);
      repeat (6) @(negedge clk);
      check("abort_no_done", done_cnt - d0, 0);
      check("abort_trunc", trunc_bits, 5);
      check("abort_sb", sb.size(), 1);
      if (sb.size() > 0) void'(sb.pop_front());
`ifdef SPI_CTRL_READBACK_EN
      check("abort_rsp_hold", rsp_data, 8'h3C);
`endif
      r0 = rise_cnt;
      send(1'b1, 7'h03, 8'h77, 16'h8377, 1'b0, hs);
      wait_ready(rdy);
      check("post_abort_latency", rdy - hs, LAT);
      check("post_abort_rises", rise_cnt - r0, 16);

      // rst and cmd_valid together: reset wins
      @(negedge clk);
      rst       = 1'b1;
      cmd_valid = 1'b1;
      cmd_write = 1'b1;
      cmd_addr  = 7'h01;
      cmd_data  = 8'h11;
      @(negedge clk);
      check("rst_valid_ready", cmd_ready, 1'b0);
      rst       = 1'b0;
      cmd_valid = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_valid_ncs", ncs, 1'b1);
      check("rst_valid_busy", busy, 1'b0);

      // Loopback into the register-bank model
      send(1'b1, 7'h00, 8'h0F, 16'h800F, 1'b0, hs);
      wait_ready(rdy);
      send(1'b1, 7'h02, 8'hF0, 16'h82F0, 1'b0, hs);
      wait_ready(rdy);
      send(1'b1, 7'h04, 8'h80, 16'h8480, 1'b0, hs);
      wait_ready(rdy);
      send(1'b1, 7'h10, 8'h55, 16'h9055, 1'b0, hs);
      wait_ready(rdy);
      check("reg_out_7_0", regs[0], 8'h0F);
      check("reg_out_15_8", regs[1], 8'hFF);
      check("reg_pwm_7_0", regs[2], 8'hF0);
      check("reg_pwm_15_8", regs[3], 8'h77);
      check("reg_duty", regs[4], 8'h80);

      repeat (4) @(negedge clk);
      check("sb_empty", sb.size(), 0);
      check("sclk_while_ncs_high", sclk_bad, 0);
      check("rsp_valid_vs_done", rv_bad, 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
